// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg: op-codes and FSM encoding shared by the shift sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer_if: command and result handshake bundle.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface shift_sequencer_if #(
  parameter int COUNT_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_data;
  logic [COUNT_W-1:0] cmd_count;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
    output cmd_ready, res_valid, res_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shifter: 4-bit combinational hold / shl / shr / rotate-left.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shifter
  import shift_pkg::*;
(
  input  wire  i3,
  input  wire  i2,
  input  wire  i1,
  input  wire  i0,
  input  wire  s1,
  input  wire  s0,
  output logic d3,
  output logic d2,
  output logic d1,
  output logic d0
);

  always_comb begin
    {d3, d2, d1, d0} = {i3, i2, i1, i0};
    case ({s1, s0})
      OP_HOLD: {d3, d2, d1, d0} = {i3, i2, i1, i0};
      OP_SHL:  {d3, d2, d1, d0} = {i2, i1, i0, 1'b0};
      OP_SHR:  {d3, d2, d1, d0} = {1'b0, i3, i2, i1};
      OP_ROT:  {d3, d2, d1, d0} = {i2, i1, i0, i3};
      default: {d3, d2, d1, d0} = {i3, i2, i1, i0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer: applies one shifter op per clock, count times, and  |
// | returns the result over a valid/ready port.   Revision: 1.0          |
// +----------------------------------------------------------------------+
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int COUNT_W = 3
) (
  input  wire              clk,
  input  wire              rst_n,
  shift_sequencer_if.slave bus
);

  state_t             state;
  logic [1:0]         op_q;
  logic [3:0]         data_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [3:0]         w_next;

  shifter u_shifter (
    .i3 (data_q[3]),
    .i2 (data_q[2]),
    .i1 (data_q[1]),
    .i0 (data_q[0]),
    .s1 (op_q[1]),
    .s0 (op_q[0]),
    .d3 (w_next[3]),
    .d2 (w_next[2]),
    .d1 (w_next[1]),
    .d0 (w_next[0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      data_q <= 4'd0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= bus.cmd_op;
            data_q <= bus.cmd_data;
            cnt_q  <= bus.cmd_count;
            state  <= (bus.cmd_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // cnt_q is never zero here, so the decrement cannot wrap
          data_q <= w_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == COUNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.res_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_sequencer: directed-vector bench for shift_sequencer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  shift_sequencer_if #(.COUNT_W(3)) bus ();

  shift_sequencer #(.COUNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns just after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge (=1) to the first edge after which res_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.res_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_data, bus.busy} !== 7'b1_0_0000_0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%b busy=%b, want 1 0 0000 0",
               bus.cmd_ready, bus.res_valid, bus.res_data, bus.busy);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rotate();
    int lat;
    send_cmd(2'b11, 4'b1001, 3'd2);
    wait_done(lat);
    vectors++;
    if (lat !== 3 || bus.res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rotate_latency: got %0d (valid=%b), want 3", lat, bus.res_valid);
    end
    vectors++;
    if (bus.res_data !== 4'b0110) begin
      miscompares++;
      $display("FAIL rotate_data: got %b, want 0110", bus.res_data);
    end
    take_result();
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rotate_handshake: got rdy=%b vld=%b, want 1 0", bus.cmd_ready, bus.res_valid);
    end
  endtask

  task automatic test_shifts();
    int lat;
    send_cmd(2'b01, 4'b1111, 3'd3);
    wait_done(lat);
    vectors++;
    if (lat !== 4 || bus.res_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL shl: got lat=%0d data=%b, want 4 1000", lat, bus.res_data);
    end
    take_result();
    send_cmd(2'b10, 4'b1001, 3'd1);
    wait_done(lat);
    vectors++;
    if (lat !== 2 || bus.res_data !== 4'b0100) begin
      miscompares++;
      $display("FAIL shr: got lat=%0d data=%b, want 2 0100", lat, bus.res_data);
    end
    take_result();
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    send_cmd(2'b00, 4'b1011, 3'd5);
    for (int i = 0; i < 5; i++) begin
      if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_run_flags: got %0d bad cycles, want 0", bad);
    end
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1011 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_done: got vld=%b data=%b busy=%b, want 1 1011 1",
               bus.res_valid, bus.res_data, bus.busy);
    end
    take_result();
  endtask

  task automatic test_zero_count();
    int lat;
    send_cmd(2'b01, 4'b0110, 3'd0);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || bus.res_data !== 4'b0110) begin
      miscompares++;
      $display("FAIL zero_count: got lat=%0d data=%b, want 1 0110", lat, bus.res_data);
    end
    take_result();
  endtask

  task automatic test_max_count();
    int lat;
    send_cmd(2'b11, 4'b0001, 3'd7);
    wait_done(lat);
    vectors++;
    if (lat !== 8 || bus.res_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL max_count: got lat=%0d data=%b, want 8 1000", lat, bus.res_data);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bad = 0;
    send_cmd(2'b01, 4'b0011, 3'd1);
    wait_done(lat);
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = (i == 1);
      bus.cmd_data  = 4'b1111;
      bus.cmd_count = 3'd0;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0110) bad++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bad !== 0 || bus.res_valid !== 1'b1 || bus.res_data !== 4'b0110) begin
      miscompares++;
      $display("FAIL backpressure_stable: got %0d bad cycles, data=%b, want 0 0110", bad, bus.res_data);
    end
    // Result accepted with a new command already waiting: one IDLE cycle, then accept.
    bus.cmd_op    = 2'b10;
    bus.cmd_data  = 4'b1000;
    bus.cmd_count = 3'd3;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_gap: got rdy=%b busy=%b, want 1 0", bus.cmd_ready, bus.busy);
    end
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL next_accept: got busy=%b rdy=%b, want 1 0", bus.busy, bus.cmd_ready);
    end
    wait_done(lat);
    vectors++;
    if (lat !== 4 || bus.res_data !== 4'b0001) begin
      miscompares++;
      $display("FAIL back_to_back: got lat=%0d data=%b, want 4 0001", lat, bus.res_data);
    end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    send_cmd(2'b11, 4'b0001, 3'd7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_data, bus.busy} !== 7'b1_0_0000_0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b data=%b busy=%b, want 1 0 0000 0",
               bus.cmd_ready, bus.res_valid, bus.res_data, bus.busy);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_idle: got vld=%b rdy=%b, want 0 1", bus.res_valid, bus.cmd_ready);
    end
    send_cmd(2'b11, 4'b1000, 3'd4);
    wait_done(lat);
    vectors++;
    if (lat !== 5 || bus.res_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL post_reset_cmd: got lat=%0d data=%b, want 5 1000", lat, bus.res_data);
    end
    take_result();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'b0000;
    bus.cmd_count = 3'd0;
    bus.res_ready = 1'b0;
    #2;
    test_reset();
    test_rotate();
    test_shifts();
    test_hold();
    test_zero_count();
    test_max_count();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
